// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction ROM,
// and buffers {pc, instr} pairs in a small FIFO toward decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [31:0]                   iAddr,
  input  logic [31:0]                   iData,
  input  logic                          fetch_en,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc,
  output logic                          out_valid,
  output logic [31:0]                   out_instr,
  output logic [31:0]                   out_pc,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fetch_err,
  output logic [1:0]                    state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     mem_pc    [FIFO_DEPTH];
  logic [31:0]     mem_instr [FIFO_DEPTH];
  logic            err_q;

  logic redir_ok, redir_bad, flush, push, pop;

  // Handshake: an entry transfers to decode on any cycle where out_valid and
  // out_ready are both high; out_valid never depends on out_ready.
  assign out_valid = (count != '0) && (state_q != ERR);
  assign pop       = out_valid & out_ready;

  // Redirects are ignored once in ERR so the frozen outputs really stay frozen.
  assign redir_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00) & (state_q != ERR);
  assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00) & (state_q != ERR);
  assign flush     = redir_ok | redir_bad;

  // IDLE with fetch_en high is already fetching on its way to RUN, which gives
  // the single-cycle latency from fetch_en to a buffered entry.
  assign push = (state_q != ERR) & fetch_en & ~redirect_valid &
                ((count < CW'(FIFO_DEPTH)) | pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      default: state_d = ERR;
    endcase
    if (redir_bad) state_d = ERR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (redir_bad) err_q <= 1'b1;
      if (redir_ok) pc_q <= redirect_pc;
      else if (push) pc_q <= pc_q + 32'd4;
      if (flush) begin
        // Keep the head pointer so the stale head values simply hold.
        wr_ptr <= rd_ptr;
        count  <= '0;
      end else begin
        if (push) begin
          mem_pc[wr_ptr]    <= pc_q;
          mem_instr[wr_ptr] <= iData;
          wr_ptr            <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  assign iAddr      = {pc_q[31:2], 2'b00};
  assign out_pc     = mem_pc[rd_ptr];
  assign out_instr  = mem_instr[rd_ptr];
  assign fifo_count = count;
  assign fetch_err  = err_q;
  assign state_dbg  = state_q;

endmodule
